// File: rtl/mio_bus_arbiter.sv
// Two-requester arbiter for the CPU and the display scanner, sharing one memory port and the
// seg7/LED peripheral registers. Sequences arbitration, memory wait states and a ready pulse.
module mio_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        MIO_ready,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] seg7_d0,
    output logic [31:0] seg7_d1,
    output logic [31:0] led_d0,
    output logic [31:0] led_d1
);

    localparam logic [31:0] Seg7Addr0 = 32'hF000_0000;
    localparam logic [31:0] Seg7Addr1 = 32'hF000_0004;
    localparam logic [31:0] LedAddr0  = 32'hE000_0000;
    localparam logic [31:0] LedAddr1  = 32'hE000_0004;
    localparam logic [3:0]  WaitLast  = WAIT_STATES[3:0];

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic        prio_q, prio_d;    // 0: CPU wins a tie, 1: scanner wins a tie
    logic        owner_q, owner_d;  // 0: CPU owns the transaction, 1: scanner
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic [31:0] seg7_0_q, seg7_0_d, seg7_1_q, seg7_1_d;
    logic [31:0] led_0_q, led_0_d, led_1_q, led_1_d;

    logic        periph_hit;
    logic        last_cycle;
    logic        mem_access;
    logic        grant_dma;
    logic [31:0] periph_rdata;
    logic [31:0] read_data;

    always_comb begin
        periph_hit   = 1'b1;
        periph_rdata = 32'd0;
        case (addr_q)
            Seg7Addr0: periph_rdata = seg7_0_q;
            Seg7Addr1: periph_rdata = seg7_1_q;
            LedAddr0:  periph_rdata = led_0_q;
            LedAddr1:  periph_rdata = led_1_q;
            default:   periph_hit   = 1'b0;
        endcase
    end

    assign last_cycle = periph_hit || (cnt_q == WaitLast);
    assign mem_access = (state_q == StAccess) && !periph_hit;
    assign grant_dma  = dma_req && (!CPU_MIO || prio_q);
    assign read_data  = periph_hit ? periph_rdata : mem_rdata;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        seg7_0_d    = seg7_0_q;
        seg7_1_d    = seg7_1_q;
        led_0_d     = led_0_q;
        led_1_d     = led_1_q;

        case (state_q)
            StIdle: begin
                if (CPU_MIO || dma_req) begin
                    owner_d = grant_dma;
                    addr_d  = grant_dma ? dma_addr : cpu_addr;
                    wdata_d = grant_dma ? 32'd0 : cpu_wdata;
                    we_d    = !grant_dma && cpu_we;
                    cnt_d   = 4'd0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (last_cycle) begin
                    state_d = StDone;
                    if (!we_q) begin
                        if (owner_q) dma_rdata_d = read_data;
                        else         cpu_rdata_d = read_data;
                    end else if (periph_hit) begin
                        case (addr_q)
                            Seg7Addr0: seg7_0_d = wdata_q;
                            Seg7Addr1: seg7_1_d = wdata_q;
                            LedAddr0:  led_0_d  = wdata_q;
                            LedAddr1:  led_1_d  = wdata_q;
                            default:   seg7_0_d = seg7_0_q;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                prio_d  = ~owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            cnt_q       <= 4'd0;
            cpu_rdata_q <= 32'd0;
            dma_rdata_q <= 32'd0;
            seg7_0_q    <= 32'd0;
            seg7_1_q    <= 32'd0;
            led_0_q     <= 32'd0;
            led_1_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            seg7_0_q    <= seg7_0_d;
            seg7_1_q    <= seg7_1_d;
            led_0_q     <= led_0_d;
            led_1_q     <= led_1_d;
        end
    end

    // Strobes are gated by reset so a transaction aborted by reset never writes or completes.
    assign MIO_ready = (state_q == StDone) && !owner_q && !reset;
    assign dma_ack   = (state_q == StDone) && owner_q && !reset;
    assign mem_addr  = mem_access ? addr_q : 32'd0;
    assign mem_wdata = mem_access ? wdata_q : 32'd0;
    assign mem_we    = mem_access && we_q && (cnt_q == WaitLast) && !reset;

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign seg7_d0   = seg7_0_q;
    assign seg7_d1   = seg7_1_q;
    assign led_d0    = led_0_q;
    assign led_d1    = led_1_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Scoreboard bench for mio_bus_arbiter: stimulus queues expected completions and memory writes,
// a negedge monitor pops and compares whenever the DUT pulses ready/ack or mem_we.
module tb_mio_bus_arbiter;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        CPU_MIO, cpu_we, MIO_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_ack;
    logic [31:0] dma_addr, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [31:0] seg7_d0, seg7_d1, led_d0, led_d1;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.WAIT_STATES(WS)) dut (
        .clk       (clk),
        .reset     (reset),
        .CPU_MIO   (CPU_MIO),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .MIO_ready (MIO_ready),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_rdata (dma_rdata),
        .dma_ack   (dma_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .seg7_d0   (seg7_d0),
        .seg7_d1   (seg7_d1),
        .led_d0    (led_d0),
        .led_d1    (led_d1)
    );

    typedef struct {
        bit          dma;
        bit          chk;
        logic [31:0] data;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    ack_t        ack_q[$];
    wr_t         wr_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] mem [0:63];

    // Memory model: preloaded on the first edge, written on mem_we, read combinationally.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
            mem[2] <= 32'h2017_031C;
            mem[8] <= 32'h1111_0008;
            mem[9] <= 32'h2222_0009;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit is_periph(input logic [31:0] a);
        return a == 32'hF000_0000 || a == 32'hF000_0004 ||
               a == 32'hE000_0000 || a == 32'hE000_0004;
    endfunction

    initial begin
        ack_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (MIO_ready || dma_ack) begin
                check("ack_exclusive", {31'd0, MIO_ready & dma_ack}, 32'd0);
                if (ack_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ready=%b ack=%b at cycle %0d, required none",
                             MIO_ready, dma_ack, cyc);
                end else begin
                    e = ack_q.pop_front();
                    check("ack_owner", {31'd0, dma_ack}, {31'd0, e.dma});
                    check("ack_cycle", cyc, e.cyc);
                    if (e.chk) check("rdata", e.dma ? dma_rdata : cpu_rdata, e.data);
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mem_we: got addr=%h data=%h at cycle %0d, required none",
                             mem_addr, mem_wdata, cyc);
                end else begin
                    w = wr_q.pop_front();
                    check("mem_addr", mem_addr, w.addr);
                    check("mem_wdata", mem_wdata, w.data);
                    check("mem_we_cycle", cyc, w.cyc);
                end
            end
        end
    end

    // Called at posedge+1 while the DUT is idle; the current cycle is T.
    task automatic issue(input bit dma, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [31:0] exp);
        ack_t e;
        wr_t  w;
        int   lat;
        lat   = is_periph(addr) ? 2 : 2 + WS;
        e.dma = dma;
        e.chk = dma || !we;
        e.data = exp;
        e.cyc = cyc + lat;
        ack_q.push_back(e);
        if (!dma && we && !is_periph(addr)) begin
            w.addr = addr;
            w.data = wdata;
            w.cyc  = cyc + 1 + WS;
            wr_q.push_back(w);
        end
        if (dma) begin
            dma_req  = 1'b1;
            dma_addr = addr;
        end else begin
            CPU_MIO   = 1'b1;
            cpu_addr  = addr;
            cpu_wdata = wdata;
            cpu_we    = we;
        end
    endtask

    task automatic wait_done(input bit dma);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dma ? dma_ack : MIO_ready) begin
                if (dma) dma_req = 1'b0;
                else     CPU_MIO = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL timeout: got no completion for dma=%0d, required one within 64 cycles", dma);
        CPU_MIO = 1'b0;
        dma_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required $finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int c;
        ack_t e;
        reset = 1'b1; CPU_MIO = 1'b0; cpu_we = 1'b0; dma_req = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; dma_addr = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_ack", {30'd0, MIO_ready, dma_ack}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_seg7_d0", seg7_d0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // CPU memory read and write
        issue(1'b0, 32'h0000_0008, 32'd0, 1'b0, 32'h2017_031C);
        wait_done(1'b0);
        issue(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'd0);
        wait_done(1'b0);
        check("mem4_written", mem[4], 32'hDEAD_BEEF);

        // Peripheral write then readback
        issue(1'b0, 32'hF000_0000, 32'h0000_1234, 1'b1, 32'd0);
        wait_done(1'b0);
        check("seg7_d0_write", seg7_d0, 32'h0000_1234);
        issue(1'b0, 32'hF000_0000, 32'd0, 1'b0, 32'h0000_1234);
        wait_done(1'b0);

        // Scanner reads with CPU write inputs set but not requested
        cpu_we = 1'b1; cpu_wdata = 32'h0000_0BAD; cpu_addr = 32'hE000_0000;
        issue(1'b1, 32'hF000_0000, 32'd0, 1'b0, 32'h0000_1234);
        wait_done(1'b1);
        issue(1'b1, 32'h0000_000C, 32'd0, 1'b0, 32'hA500_0003);
        wait_done(1'b1);
        check("led_d0_untouched", led_d0, 32'd0);
        check("cpu_rdata_hold", cpu_rdata, 32'h0000_1234);

        // Request dropped and inputs changed during ACCESS of a peripheral write
        issue(1'b0, 32'hE000_0004, 32'h0000_55AA, 1'b1, 32'd0);
        @(posedge clk);
        #1;
        CPU_MIO = 1'b0; cpu_addr = 32'hE000_0000; cpu_wdata = 32'h0000_FFFF;
        wait_done(1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("led_d1_dropped", led_d1, 32'h0000_55AA);
        check("led_d0_addr_change", led_d0, 32'd0);

        // Reset during the second ACCESS cycle of a memory write
        CPU_MIO = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'hCAFE_F00D; cpu_we = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        CPU_MIO = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", {30'd0, MIO_ready, dma_ack}, 32'd0);
        check("abort_mem_we", {31'd0, mem_we}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        check("abort_cpu_rdata", cpu_rdata, 32'd0);
        check("abort_dma_rdata", dma_rdata, 32'd0);
        check("abort_seg7_d0", seg7_d0, 32'd0);
        check("abort_led_d1", led_d1, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_mem16", mem[16], 32'hA500_0010);

        // Contention from reset: eight strictly alternating grants starting with the CPU
        do_reset();
        c = cyc;
        for (int k = 0; k < 8; k++) begin
            e.dma  = (k % 2) == 1;
            e.chk  = 1'b1;
            e.data = e.dma ? 32'h2222_0009 : 32'h1111_0008;
            e.cyc  = c + 2 + WS + k * (3 + WS);
            ack_q.push_back(e);
        end
        cpu_we = 1'b0; cpu_addr = 32'h0000_0020; dma_addr = 32'h0000_0024;
        CPU_MIO = 1'b1; dma_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 200 && seen < 8; i++) begin
            @(negedge clk);
            if (MIO_ready || dma_ack) seen++;
        end
        CPU_MIO = 1'b0; dma_req = 1'b0;
        check("contention_count", seen, 32'd8);
        repeat (4) @(posedge clk);
        #1;

        check("ack_queue_empty", ack_q.size(), 32'd0);
        check("wr_queue_empty", wr_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Shares one memory port and the memory-mapped peripheral registers (seg7 at 0xF000_0000/4, LED at 0xE000_0000/4) between two requesters.
- Requester 0 is the multi-cycle CPU (read/write). Requester 1 is a read-only display/DMA scanner.
- Sequences each transaction: arbitration, configurable memory wait states, then a one-cycle ready pulse (MIO_ready to the CPU, dma_ack to the scanner).
- Sits between Multi_CPU and the memory array in the top-level system.

Parameters:
- WAIT_STATES, 2: extra cycles the memory address is held before a memory access completes (0..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- CPU_MIO  in  1  CPU request; held high until MIO_ready.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_we  in  1  CPU write enable, qualified by CPU_MIO.
- cpu_rdata  out  32  read data returned to the CPU.
- MIO_ready  out  1  one-cycle completion pulse to the CPU.
- dma_req  in  1  scanner read request; held until dma_ack.
- dma_addr  in  32  scanner byte address.
- dma_rdata  out  32  read data returned to the scanner.
- dma_ack  out  1  one-cycle completion pulse to the scanner.
- mem_addr  out  32  address to the memory array.
- mem_wdata  out  32  write data to the memory array.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  32  combinational read data from the memory array.
- seg7_d0, seg7_d1  out  32 each  registers at 0xF000_0000 / 0xF000_0004.
- led_d0, led_d1  out  32 each  registers at 0xE000_0000 / 0xE000_0004.

Behaviour:
- Reset values:
  - state IDLE; priority pointer = CPU.
  - MIO_ready = 0, dma_ack = 0, mem_we = 0.
  - mem_addr = mem_wdata = 0; cpu_rdata = dma_rdata = 0.
  - All four peripheral registers = 0.
- Reset mid-transaction aborts it: no ready/ack pulse, no write.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is high, grant it and go to ACCESS. Latch the address, write data and we (we forced 0 for the scanner).
  - If both requests are high, grant the pointer's owner.
  - Outputs are idle; mem_we = 0.
- Address decode (exact match on the 32-bit latched address):
  - The four peripheral addresses hit peripheral registers.
  - Every other address is a memory access; mem_addr = latched address.
- ACCESS, peripheral hit: exactly 1 cycle.
  - Write: update the register at the end of that cycle.
  - Read: latch the register value.
  - Then go to DONE.
- ACCESS, memory access: exactly WAIT_STATES+1 cycles, counted by an internal 4-bit counter.
  - mem_addr and mem_wdata are stable throughout.
  - Write: mem_we = 1 only in the final ACCESS cycle.
  - Read: mem_rdata sampled at the end of the final ACCESS cycle.
  - Then go to DONE.
- DONE: exactly 1 cycle.
  - Assert MIO_ready or dma_ack (never both) and drive the latched data on cpu_rdata / dma_rdata.
  - Flip the pointer to the other requester, then return to IDLE.
- Latency, with the request sampled high in IDLE at cycle T:
  - ready/ack at T+2 for a peripheral access.
  - ready/ack at T+2+WAIT_STATES for a memory access (T+4 at default).
- Fairness: with both requesters continuously requesting, grants strictly alternate. Worst-case wait for either requester is one foreign transaction plus one IDLE cycle.
- Back-to-back: a request still high in the IDLE cycle after DONE starts a new transaction. A requester must drop its request in the DONE cycle to avoid re-issue.
- Request dropped during ACCESS: the transaction still completes, including any write, and the pulse is still issued.
- cpu_rdata / dma_rdata hold their last value between completions.
- Scanner write attempts do not exist; any peripheral write comes only from the CPU.
- Inputs other than the request are ignored outside IDLE. Address changes during ACCESS have no effect.

Test Plan:
- CPU read: reset, then CPU_MIO=1, cpu_addr=0x0000_0008, mem[2]=0x2017031C, WAIT_STATES=2 -> MIO_ready exactly one cycle at T+4; cpu_rdata=0x2017031C; mem_we never high.
- CPU write: write 0xDEADBEEF to 0x0000_0010 -> mem_we high exactly one cycle (final ACCESS cycle) with mem_addr=0x10, mem_wdata=0xDEADBEEF; MIO_ready the next cycle.
- Peripheral: write 0x1234 to 0xF000_0000, then read it back -> seg7_d0=0x1234 after the first ready (T+2); readback cpu_rdata=0x1234; mem_we stays 0.
- Contention: CPU_MIO and dma_req both held high for 8 transactions from reset -> grants CPU, DMA, CPU, DMA, ... ; MIO_ready and dma_ack never coincide.
- Reset mid-ACCESS: assert reset in the second ACCESS cycle of a memory write -> no mem_we pulse, no ready; all outputs 0 the next cycle; state IDLE.
- Dropped request: deassert CPU_MIO during ACCESS of a write to 0xE000_0004 -> led_d1 still updated; MIO_ready still pulses once; no second transaction starts.
